// File: rtl/icache_line_fill_pkg.sv
// Shared icache constants and the refill state enum.
package icache_line_fill_pkg;

  localparam int ICACHE_NO_OF_SETS     = 64;
  localparam int ICACHE_SET_ADDR_WIDTH = $clog2(ICACHE_NO_OF_SETS);
  localparam int ICACHE_BEAT_WIDTH     = 32;
  localparam int ICACHE_BEATS_PER_LINE = 4;
  localparam int ICACHE_LINE_WIDTH     = ICACHE_BEAT_WIDTH * ICACHE_BEATS_PER_LINE;

  typedef enum logic [2:0] {
    FILL_IDLE,
    FILL_REQ,
    FILL_BEATS,
    FILL_WRITE,
    FILL_DRAIN
  } fill_state_e;

endpackage

// File: rtl/icache_fill_buffer.sv
// Beat-assembly buffer and beat counter for the icache line refill.
module icache_fill_buffer #(
  parameter int BEAT_WIDTH     = 32,
  parameter int BEATS_PER_LINE = 4,
  parameter int CNT_W          = $clog2(BEATS_PER_LINE)
) (
  input  logic                                       clk,
  input  logic                                       rst_i,
  input  logic                                       clr_i,
  input  logic                                       cnt_en_i,
  input  logic                                       store_en_i,
  input  logic [BEAT_WIDTH-1:0]                      beat_i,
  output logic [CNT_W-1:0]                           cnt_o,
  output logic                                       last_o,
  output logic [BEATS_PER_LINE-1:0][BEAT_WIDTH-1:0]  line_o
);

  logic [CNT_W-1:0]                          cnt_q, cnt_d;
  logic [BEATS_PER_LINE-1:0][BEAT_WIDTH-1:0] line_q;

  // Counter wraps naturally after the last beat; clr only matters after an aborted fill.
  assign cnt_d = clr_i    ? '0 :
                 cnt_en_i ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (store_en_i) line_q[cnt_q] <= beat_i;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(BEATS_PER_LINE - 1));
  assign line_o = line_q;

endmodule

// File: rtl/icache_line_fill.sv
// Icache refill engine: one bus line read, beat assembly, single full-line data RAM write.
// Optional early-restart beat forwarding when ICACHE_FILL_FWD_EN is defined.
module icache_line_fill
  import icache_line_fill_pkg::*;
#(
  parameter int BEAT_WIDTH     = ICACHE_BEAT_WIDTH,
  parameter int BEATS_PER_LINE = ICACHE_BEATS_PER_LINE,
  parameter int LINE_WIDTH     = BEAT_WIDTH * BEATS_PER_LINE,
  parameter int SET_ADDR_WIDTH = ICACHE_SET_ADDR_WIDTH,
  parameter int CNT_W          = $clog2(BEATS_PER_LINE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fill_req_i,
  input  logic [SET_ADDR_WIDTH-1:0] fill_set_i,
  input  logic [31:0]               fill_paddr_i,
  input  logic                      fill_kill_i,
  output logic                      fill_busy_o,
  output logic                      fill_done_o,
  output logic                      mem_req_o,
  output logic [31:0]               mem_addr_o,
  input  logic                      mem_ack_i,
  input  logic                      mem_rvalid_i,
  input  logic [BEAT_WIDTH-1:0]     mem_rdata_i,
  output logic                      ram_req_o,
  output logic                      ram_wr_en_o,
  output logic [SET_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [LINE_WIDTH-1:0]     ram_wdata_o,
  output logic                      fwd_valid_o,
  output logic [CNT_W-1:0]          fwd_beat_o,
  output logic [BEAT_WIDTH-1:0]     fwd_data_o
);

  localparam logic [31:0] LINE_MASK = 32'(LINE_WIDTH / 8 - 1);

  fill_state_e               state_q, state_d;
  logic [SET_ADDR_WIDTH-1:0] set_q, set_d;
  logic [31:0]               addr_q, addr_d;
  logic                      done_q;
  logic                      accept, count, store;
  logic [CNT_W-1:0]          cnt;
  logic                      last;
  logic [BEATS_PER_LINE-1:0][BEAT_WIDTH-1:0] line;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    count   = 1'b0;
    store   = 1'b0;
    unique case (state_q)
      FILL_IDLE: begin
        if (fill_req_i && !fill_kill_i) begin
          accept  = 1'b1;
          state_d = FILL_REQ;
        end
      end
      FILL_REQ: begin
        if (mem_ack_i)        state_d = fill_kill_i ? FILL_DRAIN : FILL_BEATS;
        else if (fill_kill_i) state_d = FILL_IDLE;
      end
      FILL_BEATS: begin
        count = mem_rvalid_i;
        store = mem_rvalid_i && !fill_kill_i;
        // A kill landing on the final beat has nothing left to drain.
        if (mem_rvalid_i && last) state_d = fill_kill_i ? FILL_IDLE : FILL_WRITE;
        else if (fill_kill_i)     state_d = FILL_DRAIN;
      end
      FILL_DRAIN: begin
        count = mem_rvalid_i;
        if (mem_rvalid_i && last) state_d = FILL_IDLE;
      end
      FILL_WRITE: state_d = FILL_IDLE;
      default:    state_d = FILL_IDLE;
    endcase
  end

  assign set_d  = accept ? fill_set_i : set_q;
  assign addr_d = accept ? (fill_paddr_i & ~LINE_MASK) : addr_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= FILL_IDLE;
      set_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      addr_q  <= addr_d;
      done_q  <= (state_q == FILL_WRITE);
    end
  end

  icache_fill_buffer #(
    .BEAT_WIDTH    (BEAT_WIDTH),
    .BEATS_PER_LINE(BEATS_PER_LINE),
    .CNT_W         (CNT_W)
  ) u_buf (
    .clk       (clk),
    .rst_i     (rst_n),
    .clr_i     (accept),
    .cnt_en_i  (count),
    .store_en_i(store),
    .beat_i    (mem_rdata_i),
    .cnt_o     (cnt),
    .last_o    (last),
    .line_o    (line)
  );

  assign fill_busy_o = (state_q != FILL_IDLE);
  assign fill_done_o = done_q;
  assign mem_req_o   = (state_q == FILL_REQ);
  assign mem_addr_o  = addr_q;
  assign ram_req_o   = (state_q == FILL_WRITE);
  assign ram_wr_en_o = (state_q == FILL_WRITE);
  assign ram_addr_o  = (state_q == FILL_WRITE) ? set_q : '0;
  assign ram_wdata_o = (state_q == FILL_WRITE) ? line  : '0;

`ifdef ICACHE_FILL_FWD_EN
  logic                  fwd_valid_q;
  logic [CNT_W-1:0]      fwd_beat_q;
  logic [BEAT_WIDTH-1:0] fwd_data_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_beat_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      fwd_valid_q <= store;
      if (store) begin
        fwd_beat_q <= cnt;
        fwd_data_q <= mem_rdata_i;
      end
    end
  end

  assign fwd_valid_o = fwd_valid_q;
  assign fwd_beat_o  = fwd_beat_q;
  assign fwd_data_o  = fwd_data_q;
`else
  assign fwd_valid_o = 1'b0;
  assign fwd_beat_o  = '0;
  assign fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_icache_line_fill.sv
// Scoreboard bench for icache_line_fill: driver pushes expected RAM writes / forwarded beats,
// a negedge monitor pops and compares. Build with +define+ICACHE_FILL_FWD_EN to check forwarding.
module tb_icache_line_fill;
  import icache_line_fill_pkg::*;

  localparam int SW = ICACHE_SET_ADDR_WIDTH;
  localparam int BW = ICACHE_BEAT_WIDTH;
  localparam int NB = ICACHE_BEATS_PER_LINE;
  localparam int LW = ICACHE_LINE_WIDTH;
  localparam int CW = $clog2(NB);

  localparam int M_NORM = 0, M_KREQ = 1, M_KACK = 2, M_KBEAT = 3, M_KONBEAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fill_req_i = 1'b0;
  logic [SW-1:0] fill_set_i = '0;
  logic [31:0]   fill_paddr_i = '0;
  logic          fill_kill_i = 1'b0;
  logic          fill_busy_o, fill_done_o, mem_req_o;
  logic [31:0]   mem_addr_o;
  logic          mem_ack_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [BW-1:0] mem_rdata_i = '0;
  logic          ram_req_o, ram_wr_en_o;
  logic [SW-1:0] ram_addr_o;
  logic [LW-1:0] ram_wdata_o;
  logic          fwd_valid_o;
  logic [CW-1:0] fwd_beat_o;
  logic [BW-1:0] fwd_data_o;

  icache_line_fill dut (
    .clk(clk), .rst_n(rst_n),
    .fill_req_i(fill_req_i), .fill_set_i(fill_set_i), .fill_paddr_i(fill_paddr_i),
    .fill_kill_i(fill_kill_i), .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .ram_req_o(ram_req_o), .ram_wr_en_o(ram_wr_en_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .fwd_valid_o(fwd_valid_o), .fwd_beat_o(fwd_beat_o), .fwd_data_o(fwd_data_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [SW-1:0] set; logic [LW-1:0] line; } wr_t;
  typedef struct packed { logic [CW-1:0] beat; logic [BW-1:0] data; } fw_t;

  wr_t exp_q[$];
  fw_t fwd_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fwd(input int k, input logic [BW-1:0] d);
`ifdef ICACHE_FILL_FWD_EN
    fw_t f;
    f.beat = CW'(k);
    f.data = d;
    fwd_q.push_back(f);
`else
    if (k < 0) $display("push_fwd: bad beat %0d d=%0h", k, d);
`endif
  endtask

  // Monitor: every RAM write and forwarded beat must match the head of its queue.
  wr_t  mon_w;
  fw_t  mon_f;
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (ram_req_o || ram_wr_en_o) begin
      chk("ram_wr_en_eq_req", ram_wr_en_o, ram_req_o);
      chk("ram_write_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_w = exp_q.pop_front();
        chk("ram_addr", ram_addr_o, mon_w.set);
        chk("ram_wdata", ram_wdata_o, mon_w.line);
      end
    end
    if (fill_done_o || prev_wr) chk("done_one_cycle_after_write", fill_done_o, prev_wr);
    prev_wr = ram_req_o;
    if (mem_req_o) chk("mem_addr_aligned", mem_addr_o % (LW / 8), 0);
`ifdef ICACHE_FILL_FWD_EN
    if (fwd_valid_o) begin
      chk("fwd_expected", fwd_q.size() != 0, 1'b1);
      if (fwd_q.size() != 0) begin
        mon_f = fwd_q.pop_front();
        chk("fwd_beat", fwd_beat_o, mon_f.beat);
        chk("fwd_data", fwd_data_o, mon_f.data);
      end
    end
`else
    chk("fwd_tied_off", {fwd_valid_o, fwd_beat_o, fwd_data_o}, '0);
`endif
  end

  // One complete fill transaction; mode selects where (if anywhere) the kill lands.
  task automatic do_fill(input logic [SW-1:0] set, input logic [31:0] paddr,
                         input logic [NB-1:0][BW-1:0] bt, input int mode, input int kpos,
                         input int gap, input int ack_dly);
    logic [LW-1:0] line = '0;
    bit  killed = 0;
    bit  stored;
    int  g;
    wr_t w;
    chk("idle_before_req", fill_busy_o, 1'b0);
    fill_req_i = 1'b1; fill_set_i = set; fill_paddr_i = paddr;
    step();
    fill_req_i = 1'b0; fill_set_i = SW'($urandom); fill_paddr_i = $urandom;
    chk("mem_req_at_t1", mem_req_o, 1'b1);
    chk("busy_at_t1", fill_busy_o, 1'b1);
    chk("mem_addr", mem_addr_o, paddr - (paddr % (LW / 8)));
    for (int i = 0; i < ack_dly; i++) begin
      mem_rvalid_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;
      step();
      mem_rvalid_i = 1'b0;
      chk("mem_req_held", mem_req_o, 1'b1);
    end
    if (mode == M_KREQ) begin
      fill_kill_i = 1'b1;
      step();
      fill_kill_i = 1'b0;
      chk("mem_req_drop_on_kill", mem_req_o, 1'b0);
      chk("busy_drop_on_kill", fill_busy_o, 1'b0);
      return;
    end
    if (mode == M_NORM) begin
      for (int k = 0; k < NB; k++) line = line | (LW'(bt[k]) << (k * BW));
      w.set = set; w.line = line;
      exp_q.push_back(w);
    end
    mem_ack_i = 1'b1; fill_kill_i = (mode == M_KACK);
    step();
    mem_ack_i = 1'b0; fill_kill_i = 1'b0;
    killed = (mode == M_KACK);
    for (int k = 0; k < NB; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int i = 0; i < g; i++) begin
        step();
        chk("busy_in_gap", fill_busy_o, 1'b1);
        chk("no_write_in_gap", ram_req_o, 1'b0);
      end
      if (mode == M_KBEAT && k == kpos) begin
        fill_kill_i = 1'b1;
        step();
        fill_kill_i = 1'b0;
        killed = 1;
      end
      mem_rvalid_i = 1'b1; mem_rdata_i = bt[k];
      stored = !killed && !(mode == M_KONBEAT && k == kpos);
      if (mode == M_KONBEAT && k == kpos) begin fill_kill_i = 1'b1; killed = 1; end
      if (stored) push_fwd(k, bt[k]);
      step();
      mem_rvalid_i = 1'b0; fill_kill_i = 1'b0;
    end
    if (!killed) begin
      chk("ram_strobe_t1", ram_req_o, 1'b1);
      chk("busy_during_write", fill_busy_o, 1'b1);
      step();
      chk("done_t2", fill_done_o, 1'b1);
      chk("busy_low_t2", fill_busy_o, 1'b0);
    end else begin
      chk("no_write_after_kill", ram_req_o, 1'b0);
      chk("busy_low_after_drain", fill_busy_o, 1'b0);
      chk("no_done_after_kill", fill_done_o, 1'b0);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"}, {mem_req_o, fill_busy_o, fill_done_o, ram_req_o, ram_wr_en_o, fwd_valid_o}, '0);
    chk({name, "_data"}, {mem_addr_o, ram_addr_o, fwd_beat_o, fwd_data_o} | LW'(ram_wdata_o != 0), '0);
  endtask

  task automatic reset_mid_fill();
    fill_req_i = 1'b1; fill_set_i = SW'(3); fill_paddr_i = $urandom;
    step();
    fill_req_i = 1'b0; mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
      push_fwd(k, mem_rdata_i);
      step();
      mem_rvalid_i = 1'b0;
    end
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk_all_zero("reset_mid_fill");
    step();
    chk_all_zero("after_reset_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0][BW-1:0] bt;
    int m;
    repeat (3) step();
    chk_all_zero("in_reset");
    rst_n = 1'b0;
    step();
    chk_all_zero("reset_state");

    // Basic minimum-latency fill.
    bt = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    do_fill(SW'(5), 32'h8000_1234, bt, M_NORM, 0, 0, 0);
    // Gapped beats, 3 idle cycles each.
    do_fill(SW'(5), 32'h8000_1234, bt, M_NORM, 0, 3, 1);
    // Kill after two beats, then a clean fill to set 9.
    do_fill(SW'(7), 32'h1234_5678, bt, M_KBEAT, 2, 0, 0);
    bt = {32'hdead0003, 32'hdead0002, 32'hdead0001, 32'hdead0000};
    do_fill(SW'(9), 32'h0000_abcd, bt, M_NORM, 0, 1, 0);
    // Kill in REQ before ack, and kill with same-cycle ack.
    do_fill(SW'(2), 32'hffff_ffff, bt, M_KREQ, 0, 0, 1);
    do_fill(SW'(2), 32'h0000_0010, bt, M_KACK, 0, 1, 0);
    // Kill coinciding with the final beat.
    do_fill(SW'(4), 32'h4000_0004, bt, M_KONBEAT, NB - 1, 0, 0);
    // Synchronous reset during BEATS, then a normal fill.
    reset_mid_fill();
    bt = {32'hcafe0003, 32'hcafe0002, 32'hcafe0001, 32'hcafe0000};
    do_fill(SW'(11), 32'h2000_0fff, bt, M_NORM, 0, 0, 0);

    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < NB; k++) bt[k] = $urandom;
      m = (it % 3 == 0) ? int'($urandom_range(1, 4)) : M_NORM;
      do_fill(SW'($urandom), $urandom, bt, m, int'($urandom_range(0, NB - 1)), -1,
              int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) step();
    end

    repeat (4) step();
    chk("ram_writes_all_seen", exp_q.size(), 0);
    chk("fwd_beats_all_seen", fwd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_line_fill.md
# icache_line_fill

Instruction-cache refill engine sitting directly upstream of the icache data RAM. On a miss it issues one line read on the memory bus, assembles the returning beats into a full cache line, then performs a single full-line write into the data RAM at the miss set. It also supports a clean kill (flush) at any point of the fill.

## Interface
- BEAT_WIDTH, 32, memory bus beat width in bits
- BEATS_PER_LINE, 4, beats per cache line; power of two, ≥2
- LINE_WIDTH, BEAT_WIDTH*BEATS_PER_LINE, line width; matches data RAM DATA_WIDTH (128)
- SET_ADDR_WIDTH, $clog2(ICACHE_NO_OF_SETS), data RAM address width
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  synchronous reset, active-high: logic resets when sampled 1
- fill_req_i  input  1  single-cycle miss request; sampled only in IDLE
- fill_set_i  input  SET_ADDR_WIDTH  target set, captured with fill_req_i
- fill_paddr_i  input  32  miss physical address, captured with fill_req_i
- fill_kill_i  input  1  abandon current fill (flush)
- fill_busy_o  output  1  high in every state except IDLE
- fill_done_o  output  1  one-cycle pulse after the line write
- mem_req_o  output  1  line read request, held until mem_ack_i
- mem_addr_o  output  32  line-aligned address (low $clog2(LINE_WIDTH/8) bits zero)
- mem_ack_i  input  1  request accepted
- mem_rvalid_i  input  1  beat valid; beats arrive in order beat 0..N-1, gaps allowed
- mem_rdata_i  input  BEAT_WIDTH  beat data
- ram_req_o, ram_wr_en_o  output  1 each  data RAM strobe, both high for exactly one cycle
- ram_addr_o  output  SET_ADDR_WIDTH  data RAM set
- ram_wdata_o  output  LINE_WIDTH  assembled line
- fwd_valid_o  output  1  early-restart beat valid (see Configuration)
- fwd_beat_o  output  $clog2(BEATS_PER_LINE)  index of forwarded beat
- fwd_data_o  output  BEAT_WIDTH  forwarded beat

## Operation
- States: IDLE, REQ, BEATS, WRITE, DRAIN; state enum is the only control state.
- IDLE: fill_req_i=1 and fill_kill_i=0 → capture set and aligned address, clear beat counter, go REQ. Kill wins over a same-cycle request.
- REQ: mem_req_o=1. mem_ack_i → BEATS. fill_kill_i without ack → IDLE (mem_req_o drops next cycle). Kill with ack in the same cycle → DRAIN.
- BEATS: each mem_rvalid_i writes mem_rdata_i into line buffer slice [k*BEAT_WIDTH +: BEAT_WIDTH], k = counter; counter increments. Beat k=BEATS_PER_LINE-1 → WRITE. fill_kill_i → DRAIN (a beat in the kill cycle is counted, not stored).
- DRAIN: count remaining beats without storing; after the last beat → IDLE. No RAM write, no fill_done_o.
- WRITE: ram_req_o=ram_wr_en_o=1, ram_addr_o=captured set, ram_wdata_o=line buffer; fill_kill_i ignored (write is committed). Next cycle: IDLE with fill_done_o=1.
- Beat counter: $clog2(BEATS_PER_LINE) bits, wraps to 0 after the last beat.
- mem_rvalid_i outside BEATS/DRAIN is ignored.

## Timing
- Reset: state IDLE, counter 0, line buffer 0, every output 0.
- fill_req_i at cycle t → mem_req_o and fill_busy_o high from t+1.
- Last beat at cycle t → RAM write strobe at t+1, fill_done_o at t+2, fill_busy_o low at t+2, new fill_req_i accepted at t+2.
- Minimum fill with back-to-back beats: req t, ack t+1, beats t+2..t+5, write t+6, done t+7.
- Reset asserted mid-fill: immediate return to IDLE next edge; no RAM write, no done; outstanding bus beats are the bus's responsibility.

## Configuration
- ICACHE_FILL_FWD_EN defined: in BEATS, each stored beat is presented on fwd_data_o/fwd_beat_o with fwd_valid_o=1 the cycle after its mem_rvalid_i; nothing is forwarded in DRAIN.
- Not defined: fwd_valid_o, fwd_beat_o, fwd_data_o tied to 0; no forwarding registers.

## Structure
- Shared cache defines package: ICACHE_NO_OF_SETS, line/beat width constants, fill state enum typedef.
- Single module; beat-assembly buffer plus counter may optionally be split into sub-module icache_fill_buffer.

## Test plan
- Basic fill: req set=5, paddr=0x8000_1234 → mem_addr_o=0x8000_1230; beats 0x11111111..0x44444444 → one write at set 5, wdata 0x44444444_33333333_22222222_11111111, fill_done_o one cycle.
- Gapped beats: 3 idle cycles between each beat → same line written, write strobe exactly one cycle, busy held throughout.
- Kill in BEATS after 2 beats → no RAM write, no done; 2 more beats drained; following fill to set 9 writes correctly.
- Kill in REQ before ack → mem_req_o low next cycle, IDLE, busy low; kill with same-cycle ack → DRAIN, 4 beats consumed, no write.
- Reset asserted during BEATS → all outputs 0 next cycle, state IDLE; new fill completes normally.
- ICACHE_FILL_FWD_EN defined: fwd_valid_o pulses 4 times with fwd_beat_o 0..3 and matching data; undefined: fwd outputs stay 0.
